// File: rtl/run_detect_pkg.sv
// Shared constants and helpers for the serial run detectors: default sizes,
// the RUN_LEN legality test and the run counter width.
package run_detect_pkg;

    localparam int RUN_LEN_DEFAULT = 3;
    localparam int CNT_W_DEFAULT   = 8;

    // A run of one bit is just a bit compare, so the shortest useful run is 2.
    function automatic bit run_len_legal(input int run_len);
        return run_len >= 2;
    endfunction

    function automatic int run_cnt_width(input int run_len);
        return (run_len < 2) ? 1 : $clog2(run_len);
    endfunction

endpackage

// File: rtl/hit_counter.sv
// Wrapping hit counter with a sticky overflow flag; clear has priority over
// a simultaneous increment. Reset is synchronous and active-low.
module hit_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             hit_ovf
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign hit_cnt = cnt_q;
    assign hit_ovf = ovf_q;

endmodule

// File: rtl/run_length_detector.sv
// Serial detector for RUN_LEN consecutive valid bits equal to target.
// Define RUN_DETECT_REG_OUT_EN to register detect (one cycle later).
module run_length_detector
    import run_detect_pkg::*;
#(
    parameter int RUN_LEN = RUN_LEN_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 din_valid,
    input  logic                                 din,
    input  logic                                 target,
    input  logic                                 overlap,
    input  logic                                 clear,
    output logic                                 detect,
    output logic [run_cnt_width(RUN_LEN)-1:0]    run_cnt,
    output logic [CNT_W-1:0]                     hit_cnt,
    output logic                                 hit_ovf
);

    localparam int RCW = run_cnt_width(RUN_LEN);
    localparam logic [RCW-1:0] LAST = RCW'(RUN_LEN - 1);

    generate
        if (!run_len_legal(RUN_LEN)) begin : g_bad_run_len
            $error("run_length_detector: RUN_LEN must be at least 2");
        end
    endgenerate

    logic [RCW-1:0] run_cnt_q, run_cnt_d;
    logic           match;
    logic           at_last;
    logic           complete;

    assign match    = din_valid && (din == target);
    assign at_last  = (run_cnt_q == LAST);
    assign complete = reset && match && at_last;

    // Invalid bits are bubbles: they neither extend nor break a run.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (din_valid) begin
            if (din != target) begin
                run_cnt_d = '0;
            end else if (!at_last) begin
                run_cnt_d = run_cnt_q + RCW'(1);
            end else if (!overlap) begin
                run_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end

    assign run_cnt = run_cnt_q;

`ifdef RUN_DETECT_REG_OUT_EN
    logic detect_q, detect_d;

    always_comb begin
        detect_d = complete;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            detect_q <= 1'b0;
        end else begin
            detect_q <= detect_d;
        end
    end

    assign detect = detect_q;
`else
    assign detect = complete;
`endif

    // Counting the completing bit directly keeps hit_cnt aligned with the
    // registered detect edge as well as the combinational one.
    hit_counter #(
        .CNT_W (CNT_W)
    ) u_hit_counter (
        .clk     (clk),
        .reset   (reset),
        .inc     (complete),
        .clear   (clear),
        .hit_cnt (hit_cnt),
        .hit_ovf (hit_ovf)
    );

endmodule

// File: tb/tb_run_length_detector.sv
// Self-checking bench for run_length_detector (RUN_LEN=3, CNT_W=2);
// detect expectations shift by one cycle when RUN_DETECT_REG_OUT_EN is set.
module tb_run_length_detector;

    localparam int RUN_LEN = 3;
    localparam int CNT_W   = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             din_valid;
    logic             din;
    logic             target;
    logic             overlap;
    logic             clear;
    logic             detect;
    logic [1:0]       run_cnt;
    logic [CNT_W-1:0] hit_cnt;
    logic             hit_ovf;

    typedef struct {
        string       tag;
        logic        det;
        logic [1:0]  run;
        logic [1:0]  hit;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   tx_idx = 0;
    logic prev_det = 1'b0;

    always #5 clk = ~clk;

    run_length_detector #(
        .RUN_LEN (RUN_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din_valid (din_valid),
        .din       (din),
        .target    (target),
        .overlap   (overlap),
        .clear     (clear),
        .detect    (detect),
        .run_cnt   (run_cnt),
        .hit_cnt   (hit_cnt),
        .hit_ovf   (hit_ovf)
    );

    // One bit per call, entered at posedge+1. e_det is the combinational
    // (same-bit) detect; e_run/e_hit/e_ovf are the values after the edge.
    task automatic step(input string tag, input logic r, input logic v, input logic d,
                        input logic t, input logic o, input logic c,
                        input logic e_det, input int e_run, input int e_hit, input logic e_ovf);
        exp_t e;
        exp_t got;
        e.tag = tag;
`ifdef RUN_DETECT_REG_OUT_EN
        e.det = prev_det;
`else
        e.det = e_det;
`endif
        prev_det = e_det;
        e.run = 2'(e_run);
        e.hit = 2'(e_hit);
        e.ovf = e_ovf;
        exp_q.push_back(e);

        reset = r; din_valid = v; din = d; target = t; overlap = o; clear = c;
        @(negedge clk);
        got = exp_q[0];
        checks++;
        if (detect !== got.det) begin
            errors++;
            $display("FAIL %s[%0d] detect: got %b expected %b", got.tag, tx_idx, detect, got.det);
        end
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        checks++;
        if (run_cnt !== got.run) begin
            errors++;
            $display("FAIL %s[%0d] run_cnt: got %0d expected %0d", got.tag, tx_idx, run_cnt, got.run);
        end
        checks++;
        if (hit_cnt !== got.hit) begin
            errors++;
            $display("FAIL %s[%0d] hit_cnt: got %0d expected %0d", got.tag, tx_idx, hit_cnt, got.hit);
        end
        checks++;
        if (hit_ovf !== got.ovf) begin
            errors++;
            $display("FAIL %s[%0d] hit_ovf: got %b expected %b", got.tag, tx_idx, hit_ovf, got.ovf);
        end
        $display("tx %0d %s: rst=%b v=%b d=%b t=%b o=%b clr=%b -> det=%b run=%0d hit=%0d ovf=%b",
                 tx_idx, tag, r, v, d, t, o, c, detect, run_cnt, hit_cnt, hit_ovf);
        tx_idx++;
    endtask

    task automatic test_reset();
        step("reset", 0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        step("reset", 0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_overlap();
        step("overlap", 1, 1, 1, 1, 1, 0, 0, 1, 0, 0);
        step("overlap", 1, 1, 1, 1, 1, 0, 0, 2, 0, 0);
        step("overlap", 1, 1, 1, 1, 1, 0, 1, 2, 1, 0);
        step("overlap", 1, 1, 1, 1, 1, 0, 1, 2, 2, 0);
        step("overlap", 1, 1, 0, 1, 1, 0, 0, 0, 2, 0);
        step("overlap_clr", 1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic test_non_overlap();
        step("nonovl", 1, 1, 1, 1, 0, 0, 0, 1, 0, 0);
        step("nonovl", 1, 1, 1, 1, 0, 0, 0, 2, 0, 0);
        step("nonovl", 1, 1, 1, 1, 0, 0, 1, 0, 1, 0);
        step("nonovl", 1, 1, 1, 1, 0, 0, 0, 1, 1, 0);
        step("nonovl", 1, 1, 1, 1, 0, 0, 0, 2, 1, 0);
        step("nonovl", 1, 1, 1, 1, 0, 0, 1, 0, 2, 0);
        step("nonovl_clr", 1, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_bubble();
        step("bubble", 1, 1, 1, 1, 1, 0, 0, 1, 0, 0);
        step("bubble", 1, 0, 1, 1, 1, 0, 0, 1, 0, 0);
        step("bubble", 1, 1, 1, 1, 1, 0, 0, 2, 0, 0);
        step("bubble", 1, 1, 1, 1, 1, 0, 1, 2, 1, 0);
        step("bubble", 1, 1, 0, 1, 1, 0, 0, 0, 1, 0);
        step("bubble_clr", 1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic test_target0();
        step("target0", 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        step("target0", 1, 1, 0, 0, 0, 0, 0, 2, 0, 0);
        step("target0", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step("target0", 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        step("target0", 1, 1, 0, 0, 0, 0, 0, 2, 0, 0);
        step("target0", 1, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        step("target0_clr", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_overflow();
        step("ovf", 1, 1, 1, 1, 1, 0, 0, 1, 0, 0);
        step("ovf", 1, 1, 1, 1, 1, 0, 0, 2, 0, 0);
        step("ovf", 1, 1, 1, 1, 1, 0, 1, 2, 1, 0);
        step("ovf", 1, 1, 1, 1, 1, 0, 1, 2, 2, 0);
        step("ovf", 1, 1, 1, 1, 1, 0, 1, 2, 3, 0);
        step("ovf", 1, 1, 1, 1, 1, 0, 1, 2, 0, 1);
        step("ovf", 1, 1, 1, 1, 1, 0, 1, 2, 1, 1);
        // clear on a detecting bit: the hit is dropped, the run is kept
        step("ovf_clr_det", 1, 1, 1, 1, 1, 1, 1, 2, 0, 0);
        step("ovf_after", 1, 1, 1, 1, 1, 0, 1, 2, 1, 0);
        step("ovf_after", 1, 1, 0, 1, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_run();
        step("rst_mid", 1, 1, 1, 1, 1, 0, 0, 1, 0, 0);
        step("rst_mid", 1, 1, 1, 1, 1, 0, 0, 2, 0, 0);
        step("rst_mid", 0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        step("rst_mid", 1, 1, 1, 1, 1, 0, 0, 1, 0, 0);
        step("rst_mid", 1, 1, 1, 1, 1, 0, 0, 2, 0, 0);
        step("rst_mid", 1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        step("tgt_chg", 1, 1, 1, 1, 1, 0, 0, 1, 0, 0);
        step("tgt_chg", 1, 1, 1, 1, 1, 0, 0, 2, 0, 0);
        step("tgt_chg", 1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        step("tgt_chg", 1, 1, 0, 0, 1, 0, 0, 1, 0, 0);
        step("ovl_chg", 1, 1, 0, 0, 1, 0, 0, 2, 0, 0);
        step("ovl_chg", 1, 1, 0, 0, 1, 0, 1, 2, 1, 0);
        step("ovl_chg", 1, 1, 0, 0, 0, 0, 1, 0, 2, 0);
        step("ovl_chg", 1, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    endtask

    initial begin
        reset = 1'b0; din_valid = 1'b0; din = 1'b0;
        target = 1'b1; overlap = 1'b1; clear = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_bubble();
        test_target0();
        test_overflow();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/run_length_detector.md
Name: run_length_detector

Overview:
- Parametrised serial run-length detector, successor to the fixed three-ones detector.
- Flags when RUN_LEN consecutive valid bits equal a runtime-selectable target value.
- Supports an overlapping or non-overlapping mode and counts hits.
- Sits on a serial bit stream feeding the protocol/monitor logic; the stream may have bubbles (qualified by din_valid).

Parameters:
- RUN_LEN, 3, run length to detect; legal range >= 2.
- CNT_W, 8, width of the hit counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- din_valid  input  1  qualifies din; when low, the bit is ignored.
- din  input  1  serial data bit.
- target  input  1  bit value whose runs are detected; sampled per bit.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- clear  input  1  synchronous clear of hit_cnt and hit_ovf.
- detect  output  1  high for the bit that completes a run.
- run_cnt  output  $clog2(RUN_LEN)  current matched run length, range 0..RUN_LEN-1.
- hit_cnt  output  CNT_W  number of detections, modulo 2^CNT_W.
- hit_ovf  output  1  sticky flag; set when hit_cnt wraps.

Behaviour:
- Reset (reset==0 at a rising edge): run_cnt=0, hit_cnt=0, hit_ovf=0. detect is forced 0 while reset is low.
- Bit match: match = din_valid && (din==target). Matching uses the target value present in the same cycle.
- detect (Mealy, combinational): detect = reset && match && (run_cnt==RUN_LEN-1). No latency.
- run_cnt next-state, in priority order:
  - din_valid==0: hold.
  - din!=target: go to 0.
  - match with run_cnt<RUN_LEN-1: increment.
  - match with run_cnt==RUN_LEN-1 and overlap=1: stay at RUN_LEN-1. Every further matching bit detects again.
  - match with run_cnt==RUN_LEN-1 and overlap=0: go to 0. A new run must be a full RUN_LEN long.
- Changing target mid-run needs no special handling: the first bit that differs from the new target resets the run.
- Changing overlap mid-run takes effect on the next completing bit.
- hit_cnt:
  - Increments by 1 at the edge after each detect.
  - Wraps from all-ones to 0, setting hit_ovf on that same edge.
  - hit_ovf stays set until clear or reset.
- clear=1: hit_cnt<=0 and hit_ovf<=0. clear wins over a simultaneous detect, so that hit is not counted. clear does not affect run_cnt or detect.
- Reset mid-run: the partial run is discarded; the next bit starts from run_cnt=0.

Optional Feature:
- Macro: RUN_DETECT_REG_OUT_EN.
- Defined: detect is registered, asserting one cycle after the completing bit. Its reset value is 0 and reset clears it. hit_cnt timing is unchanged: it increments on the same edge that detect rises.
- Undefined: detect is the combinational Mealy output described above.

Decomposition:
- Package run_detect_pkg holds:
  - the default RUN_LEN and CNT_W constants;
  - the RUN_LEN>=2 legality check;
  - a function returning the run_cnt width.
- Sub-module hit_counter (parameter CNT_W) holds hit_cnt and hit_ovf, with inputs inc and clear. It is reusable by the other monitors.
- The run tracking stays in the top module.

Test Plan:
- RUN_LEN=3, target=1, overlap=1, din=1,1,1,1,0 (all valid) -> detect=0,0,1,1,0; run_cnt=1,2,2,2,0 after each edge; hit_cnt=2.
- overlap=0, target=1, six 1s -> detect on bits 3 and 6 only; run_cnt after bit 3 = 0; hit_cnt=2.
- din_valid pattern 1,0,1,1 with din=1 throughout -> run_cnt holds at 1 across the bubble; detect on the 4th cycle; hit_cnt=1.
- target=0, din=0,0,1,0,0,0 -> single detect on the last bit; the 1 resets run_cnt to 0.
- CNT_W=2, overlap=1, seven consecutive 1s (5 detects) -> hit_cnt goes 1,2,3,0,1 and hit_ovf=1 from the 4th hit. Then clear=1 -> hit_cnt=0, hit_ovf=0. Also clear asserted on a detect cycle -> hit_cnt=0.
- Two 1s, then reset low for one cycle, then 1,1 -> no detect; run_cnt=2 after reset is released. With RUN_DETECT_REG_OUT_EN defined, repeat test 1 -> detect=0,0,0,1,1.
